// File: rtl/fb_sched_pkg.sv
// rtl/fb_sched_pkg.sv - shared types and default sizes for the frameblock scheduler
// Contents:
//   buf_state_e        per-buffer lifecycle EMPTY -> RENDER -> FULL -> SHOW -> EMPTY
//   render_state_e     render job FSM states
//   NUM_BLOCKS_DEFAULT frameblocks per frame (320x240 / 1024 px)
//   ID_W_DEFAULT       block ID width
package fb_sched_pkg;

  localparam int NUM_BLOCKS_DEFAULT = 75;
  localparam int ID_W_DEFAULT       = 7;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    RENDER = 2'd1,
    FULL   = 2'd2,
    SHOW   = 2'd3
  } buf_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } render_state_e;

endpackage

// File: rtl/fb_wrap_counter.sv
// rtl/fb_wrap_counter.sv - block ID counter wrapping at NUM_BLOCKS-1
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears count to 0
//   inc    in   advance the count by one on this edge
//   count  out  current block ID, 0..NUM_BLOCKS-1
//   wrap   out  combinational; high when inc is applied to the last ID
module fb_wrap_counter
  import fb_sched_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
  parameter int ID_W       = ID_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [ID_W-1:0] count,
  output logic            wrap
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_BLOCKS - 1);

  assign wrap = inc && (count == LAST_ID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/frameblock_scheduler.sv
// rtl/frameblock_scheduler.sv - ping-pong render/display sequencing of frameblocks
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-low reset
//   enable           in   permits issuing new render jobs
//   render_start     out  one-cycle pulse starting a render job
//   render_id        out  block being rendered, held until render_done
//   render_buf       out  target buffer of the current render job
//   render_done      in   one-cycle pulse, current render job complete
//   frameblock_id    out  block held in the display buffer
//   frameblock_ready out  display buffer holds a complete block
//   frameblock_next  in   one-cycle pulse, displayed block consumed
//   disp_buf         out  buffer selected for display reads
//   frame_done       out  one-cycle pulse after releasing the last block of a frame
module frameblock_scheduler
  import fb_sched_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
  parameter int ID_W       = ID_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic            render_start,
  output logic [ID_W-1:0] render_id,
  output logic            render_buf,
  input  logic            render_done,
  output logic [ID_W-1:0] frameblock_id,
  output logic            frameblock_ready,
  input  logic            frameblock_next,
  output logic            disp_buf,
  output logic            frame_done
);

  render_state_e rstate, rstate_nxt;
  buf_state_e    buf_st  [2];
  buf_state_e    buf_nxt [2];
  logic          wr_sel, wr_sel_nxt;
  logic          rd_sel, rd_sel_nxt;
  logic          start_nxt;
  logic          ready_nxt;
  logic          render_inc;
  logic          disp_inc;
  logic          disp_wrap;
  logic          render_wrap_unused;

  // Render side and display side only ever touch different buffers in the
  // same cycle: the render target is RENDER while the display side only acts
  // on a FULL or SHOW buffer, so both updates can be merged without priority.
  always_comb begin
    rstate_nxt = rstate;
    buf_nxt[0] = buf_st[0];
    buf_nxt[1] = buf_st[1];
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    start_nxt  = 1'b0;
    render_inc = 1'b0;
    disp_inc   = 1'b0;

    case (rstate)
      IDLE: begin
        if (enable && (buf_st[wr_sel] == EMPTY)) begin
          rstate_nxt      = BUSY;
          start_nxt       = 1'b1;
          buf_nxt[wr_sel] = RENDER;
        end
      end
      BUSY: begin
        if (render_done) begin
          rstate_nxt      = IDLE;
          buf_nxt[wr_sel] = FULL;
          wr_sel_nxt      = ~wr_sel;
          render_inc      = 1'b1;
        end
      end
      default: rstate_nxt = IDLE;
    endcase

    if (buf_st[rd_sel] == FULL) begin
      buf_nxt[rd_sel] = SHOW;
    end else if (frameblock_next && frameblock_ready) begin
      buf_nxt[rd_sel] = EMPTY;
      rd_sel_nxt      = ~rd_sel;
      disp_inc        = 1'b1;
    end

    // Registered view of the display buffer state after this edge.
    ready_nxt = (buf_nxt[rd_sel_nxt] == SHOW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate           <= IDLE;
      buf_st[0]        <= EMPTY;
      buf_st[1]        <= EMPTY;
      wr_sel           <= 1'b0;
      rd_sel           <= 1'b0;
      render_start     <= 1'b0;
      render_buf       <= 1'b0;
      frameblock_ready <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      rstate           <= rstate_nxt;
      buf_st[0]        <= buf_nxt[0];
      buf_st[1]        <= buf_nxt[1];
      wr_sel           <= wr_sel_nxt;
      rd_sel           <= rd_sel_nxt;
      render_start     <= start_nxt;
      if (start_nxt) begin
        render_buf <= wr_sel;
      end
      frameblock_ready <= ready_nxt;
      frame_done       <= disp_wrap;
    end
  end

  assign disp_buf = rd_sel;

  fb_wrap_counter #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .ID_W       (ID_W)
  ) u_render_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (render_inc),
    .count (render_id),
    .wrap  (render_wrap_unused)
  );

  fb_wrap_counter #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .ID_W       (ID_W)
  ) u_disp_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (disp_inc),
    .count (frameblock_id),
    .wrap  (disp_wrap)
  );

endmodule

// File: tb/tb_frameblock_scheduler.sv
// tb/tb_frameblock_scheduler.sv - scoreboard bench for frameblock_scheduler
module tb_frameblock_scheduler;

  localparam int NB = 75;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          render_start;
  logic [IW-1:0] render_id;
  logic          render_buf;
  logic          render_done = 1'b0;
  logic [IW-1:0] frameblock_id;
  logic          frameblock_ready;
  logic          frameblock_next = 1'b0;
  logic          disp_buf;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int fd_seen = 0;
  int sb[$];
  int exp_render_id = 0;
  int exp_id;
  logic exp_wr = 1'b0;
  logic exp_rd = 1'b0;

  frameblock_scheduler #(.NUM_BLOCKS(NB), .ID_W(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .render_start     (render_start),
    .render_id        (render_id),
    .render_buf       (render_buf),
    .render_done      (render_done),
    .frameblock_id    (frameblock_id),
    .frameblock_ready (frameblock_ready),
    .frameblock_next  (frameblock_next),
    .disp_buf         (disp_buf),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) fd_seen++;
  endtask

  // Check a render_start sampled now and record the block for display order.
  task automatic expect_start(input string tag);
    chk({tag, "_start"}, int'(render_start), 1);
    chk({tag, "_rid"}, int'(render_id), exp_render_id);
    chk({tag, "_rbuf"}, int'(render_buf), int'(exp_wr));
    sb.push_back(exp_render_id);
    exp_wr = ~exp_wr;
    exp_render_id = (exp_render_id + 1) % NB;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_start", int'(render_start), 0);
    chk("rst_rid", int'(render_id), 0);
    chk("rst_rbuf", int'(render_buf), 0);
    chk("rst_fid", int'(frameblock_id), 0);
    chk("rst_ready", int'(frameblock_ready), 0);
    chk("rst_disp", int'(disp_buf), 0);
    chk("rst_fdone", int'(frame_done), 0);

    // Out of reset with enable low: stale render_done and spurious
    // frameblock_next must change nothing.
    rst = 1'b1;
    tick();
    render_done = 1'b1;
    frameblock_next = 1'b1;
    tick();
    render_done = 1'b0;
    frameblock_next = 1'b0;
    tick();
    chk("spur_start", int'(render_start), 0);
    chk("spur_rid", int'(render_id), 0);
    chk("spur_fid", int'(frameblock_id), 0);
    chk("spur_ready", int'(frameblock_ready), 0);
    chk("spur_disp", int'(disp_buf), 0);

    // First render job
    enable = 1'b1;
    tick();
    expect_start("first");
    tick();
    chk("first_pulse", int'(render_start), 0);
    tick();
    chk("first_noready", int'(frameblock_ready), 0);
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    chk("n_ready", int'(frameblock_ready), 0);
    tick();
    chk("n1_ready", int'(frameblock_ready), 1);
    chk("n1_fid", int'(frameblock_id), 0);
    chk("n1_disp", int'(disp_buf), 0);
    expect_start("n1");

    // Steady pipeline: render k completes, display releases k-1, render k+1
    // starts one edge after the release. Runs past a full frame and wraps.
    for (int k = 1; k <= 79; k++) begin
      tick();
      tick();
      chk("busy_start", int'(render_start), 0);
      render_done = 1'b1;
      tick();
      render_done = 1'b0;
      tick();
      tick();
      chk("stall_start", int'(render_start), 0);
      chk("stall_fdone", int'(frame_done), 0);
      chk("show_ready", int'(frameblock_ready), 1);
      chk("show_disp", int'(disp_buf), int'(exp_rd));
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        exp_id = sb.pop_front();
        chk("show_fid", int'(frameblock_id), exp_id);
      end
      frameblock_next = 1'b1;
      tick();
      frameblock_next = 1'b0;
      chk("m_ready", int'(frameblock_ready), 0);
      chk("m_start", int'(render_start), 0);
      chk("m_fdone", int'(frame_done), (exp_id == NB - 1) ? 1 : 0);
      exp_rd = ~exp_rd;
      tick();
      chk("m1_fdone", int'(frame_done), 0);
      chk("m1_ready", int'(frameblock_ready), 1);
      chk("m1_disp", int'(disp_buf), int'(exp_rd));
      expect_start("m1");
    end
    chk("fdone_count", fd_seen, 1);

    // Mid-render reset with a block on display: block 5 rendering, 4 shown.
    chk("pre_rst_rid", int'(render_id), 5);
    chk("pre_rst_ready", int'(frameblock_ready), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_start", int'(render_start), 0);
    chk("mid_rst_rid", int'(render_id), 0);
    chk("mid_rst_fid", int'(frameblock_id), 0);
    chk("mid_rst_ready", int'(frameblock_ready), 0);
    chk("mid_rst_disp", int'(disp_buf), 0);
    chk("mid_rst_rbuf", int'(render_buf), 0);
    sb.delete();
    exp_render_id = 0;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    expect_start("restart");
    chk("restart_fid", int'(frameblock_id), 0);
    chk("restart_ready", int'(frameblock_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
